// File: rtl/noc_root_sink.sv
`default_nettype none
// ============================================================================
// Module      : noc_root_sink
// Description : Tree-root consumer that buffers enh_mux output in a FWFT FIFO,
//               raises registered busy early and counts dropped words.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_root_sink #(
  parameter int word_width     = 16,
  parameter int val_bit        = 1,
  parameter int log_buffer_len = 3,
  parameter int skid           = 3
) (
  input  logic                           clk_r,
  input  logic                           rst,
  input  logic [word_width-1:0]          in,
  output logic                           busy,
  output logic [word_width-val_bit-1:0]  out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [log_buffer_len:0]        count,
  output logic                           overflow,
  output logic [7:0]                     drop_cnt
);

  localparam int                    c_pw    = word_width - val_bit;
  localparam int                    c_depth = 2 ** log_buffer_len;
  localparam logic [log_buffer_len:0] c_full  = (log_buffer_len + 1)'(c_depth);
  localparam logic [log_buffer_len:0] c_thr   = (log_buffer_len + 1)'(c_depth - skid);

  logic [c_pw-1:0]             r_mem [c_depth];
  logic [log_buffer_len-1:0]   r_wr_ptr;
  logic [log_buffer_len-1:0]   r_rd_ptr;
  logic [log_buffer_len:0]     r_count;
  logic                        r_busy;
  logic                        r_overflow;
  logic [7:0]                  r_drop_cnt;

  logic                        w_push_req;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_push_ok;
  logic                        w_drop;
  logic [log_buffer_len:0]     w_count_next;

  assign w_push_req = in[word_width-1];
  assign w_full     = (r_count == c_full);
  assign out_valid  = (r_count != '0);
  assign out_data   = r_mem[r_rd_ptr];
  assign w_pop      = out_valid & out_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push_ok  = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push_ok && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_r) begin
    if (rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= in[c_pw-1:0];
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      // Raised early so words already in flight in the mux still find room.
      r_busy  <= (w_count_next >= c_thr);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_noc_root_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_root_sink
// Description : Directed self-checking bench for noc_root_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_root_sink;

  logic        clk_r;
  logic        rst;
  logic [15:0] in;
  logic        busy;
  logic [14:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int          n_tests;
  int          n_failed;
  logic [14:0] exp_q [$];
  logic [14:0] head;

  noc_root_sink #(
    .word_width     (16),
    .val_bit        (1),
    .log_buffer_len (3),
    .skid           (3)
  ) u_dut (
    .clk_r     (clk_r),
    .rst       (rst),
    .in        (in),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk_r = 1'b0;
  always #5 clk_r = ~clk_r;

  task automatic tick();
    @(posedge clk_r);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_failed  = 0;
    rst       = 1'b1;
    in        = 16'h8001;
    out_ready = 1'b0;

    // 1. reset with valid toggling
    tick();
    in = 16'h0000;
    tick();
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_drop",     32'(drop_cnt),  32'd0);
    chk("rst_data",     32'(out_data),  32'd0);
    rst = 1'b0;
    tick();
    chk("idle_count",   32'(count),     32'd0);

    // 2. single word, 1-cycle latency, popped
    in        = 16'h8ABC;
    out_ready = 1'b1;
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'h0ABC);
    chk("single_cnt1",  32'(count),     32'd1);
    in = 16'h0000;
    tick();
    chk("single_cnt0",  32'(count),     32'd0);
    chk("single_empty", 32'(out_valid), 32'd0);

    // 3. fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in = 16'h8000 | 16'(i);
      exp_q.push_back(15'(i));
      tick();
      if (i == 4) begin
        chk("fill4_busy",  32'(busy),  32'd0);
        chk("fill4_count", 32'(count), 32'd4);
      end
      if (i == 5) begin
        chk("fill5_busy",  32'(busy),  32'd1);
        chk("fill5_count", 32'(count), 32'd5);
      end
    end
    chk("full_count",    32'(count),    32'd8);
    chk("full_overflow", 32'(overflow), 32'd0);
    chk("full_head",     32'(out_data), 32'd1);
    in = 16'h8009;
    tick();
    chk("drop_count",    32'(count),    32'd8);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_cnt1",     32'(drop_cnt), 32'd1);

    // 4. push and pop together while full, streamed across pointer wrap
    in        = 16'h8010;
    out_ready = 1'b1;
    head = exp_q.pop_front();
    chk("pp_head", 32'(out_data), 32'(head));
    exp_q.push_back(15'h0010);
    tick();
    chk("pp_count", 32'(count),    32'd8);
    chk("pp_drop",  32'(drop_cnt), 32'd1);
    chk("pp_head2", 32'(out_data), 32'd2);
    for (int k = 0; k < 20; k++) begin
      in   = 16'h8000 | (16'h0020 + 16'(k));
      head = exp_q.pop_front();
      chk("stream_data", 32'(out_data), 32'(head));
      exp_q.push_back(15'h0020 + 15'(k));
      tick();
    end
    chk("stream_count", 32'(count),    32'd8);
    chk("stream_drop",  32'(drop_cnt), 32'd1);
    chk("stream_busy",  32'(busy),     32'd1);

    // 5. drain; busy falls when occupancy reaches 4
    in = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      head = exp_q.pop_front();
      chk("drain_data", 32'(out_data), 32'(head));
      tick();
      chk("drain_count", 32'(count), 32'(8 - k));
      chk("drain_busy",  32'(busy),  (k < 4) ? 32'd1 : 32'd0);
    end
    chk("drain_valid", 32'(out_valid), 32'd0);
    tick();
    chk("empty_ready_count", 32'(count), 32'd0);

    // 6. saturation of drop counter, then mid-stream reset
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in = 16'h8100 | 16'(k);
      tick();
    end
    chk("sat_fill", 32'(count), 32'd8);
    for (int k = 0; k < 300; k++) begin
      in = 16'h8200 | 16'(k);
      tick();
    end
    chk("sat_drop",     32'(drop_cnt), 32'd255);
    chk("sat_overflow", 32'(overflow), 32'd1);
    chk("sat_count",    32'(count),    32'd8);
    chk("sat_head",     32'(out_data), 32'h0100);
    rst = 1'b1;
    tick();
    chk("mrst_count",    32'(count),     32'd0);
    chk("mrst_busy",     32'(busy),      32'd0);
    chk("mrst_valid",    32'(out_valid), 32'd0);
    chk("mrst_overflow", 32'(overflow),  32'd0);
    chk("mrst_drop",     32'(drop_cnt),  32'd0);
    chk("mrst_data",     32'(out_data),  32'd0);
    rst = 1'b0;
    in  = 16'h0000;
    tick();
    chk("post_count", 32'(count),     32'd0);
    chk("post_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
`default_nettype wire
